// File: rtl/square_oscillator_if.sv
// Control and readback bundle between the voice sequencer (master) and the
// square oscillator voice (slave).
interface square_oscillator_if #(
  parameter int WIDTH = 32
);
  logic             set;
  logic [WIDTH-1:0] set_sample;
  logic [WIDTH-1:0] set_counter;
  logic [WIDTH-1:0] wave_length;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] filtered_out;

  modport master (
    output set, set_sample, set_counter, wave_length,
    input  counter, out, filtered_out
  );

  modport slave (
    input  set, set_sample, set_counter, wave_length,
    output counter, out, filtered_out
  );
endinterface

// File: rtl/square_oscillator.sv
// Fixed-point square-wave voice with loadable phase state, followed by a
// single-pole IIR low-pass (coefficient 2^-(FILTER_SHIFT+1)).
module square_oscillator #(
  parameter int WIDTH        = 32,
  parameter int FRAC_BITS    = 20,
  parameter int FILTER_SHIFT = 0
) (
  input  logic                clk,
  input  logic                reset,
  square_oscillator_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   STEP      = {{WIDTH{1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic [WIDTH-1:0] STEP_W    = STEP[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] RESET_OUT = ~STEP_W + ONE;

  localparam logic signed [WIDTH+1:0] MAX_EXT = {2'b00, MAX_VAL};
  localparam logic signed [WIDTH+1:0] MIN_EXT = {2'b11, MIN_VAL};

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] filt_q, filt_d;

  logic [WIDTH-1:0] src_sample, src_counter, neg_sample, half;
  logic [WIDTH:0]   n_ext, half_ext, wrap_ext;

  always_comb begin
    src_sample  = bus.set ? bus.set_sample  : out_q;
    src_counter = bus.set ? bus.set_counter : counter_q;
    half        = bus.wave_length >> 1;
    half_ext    = {1'b0, half};
    // One extra bit so a counter near full scale cannot wrap before the compare.
    n_ext       = {1'b0, src_counter} + STEP;
    wrap_ext    = n_ext - half_ext;
    neg_sample  = (src_sample == MIN_VAL) ? MAX_VAL : (~src_sample + ONE);

    counter_d = WIDTH'(n_ext);
    out_d     = src_sample;
    if (half == '0) begin
      counter_d = '0;
      out_d     = src_sample;
    end else if (half_ext <= STEP) begin
      counter_d = '0;
      out_d     = neg_sample;
    end else if (n_ext >= half_ext) begin
      counter_d = WIDTH'(wrap_ext);
      out_d     = neg_sample;
    end
  end

  logic signed [WIDTH+1:0] out_ext, filt_ext, diff_ext, delta_ext, sum_ext;

  always_comb begin
    out_ext   = {{2{out_q[WIDTH-1]}}, out_q};
    filt_ext  = {{2{filt_q[WIDTH-1]}}, filt_q};
    diff_ext  = out_ext - filt_ext;
    // Arithmetic shift floors toward -inf, so a rising approach settles one LSB short.
    delta_ext = diff_ext >>> (FILTER_SHIFT + 1);
    sum_ext   = filt_ext + delta_ext;
    if (sum_ext > MAX_EXT) begin
      filt_d = MAX_VAL;
    end else if (sum_ext < MIN_EXT) begin
      filt_d = MIN_VAL;
    end else begin
      filt_d = WIDTH'(sum_ext);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      out_q     <= RESET_OUT;
      filt_q    <= '0;
    end else begin
      counter_q <= counter_d;
      out_q     <= out_d;
      filt_q    <= filt_d;
    end
  end

  assign bus.counter      = counter_q;
  assign bus.out          = out_q;
  assign bus.filtered_out = filt_q;

endmodule

// File: tb/tb_square_oscillator.sv
// Scoreboard bench for square_oscillator: stimulus pushes hand-computed
// expectations tagged with a cycle number; a monitor pops and compares them.
module tb_square_oscillator;

  localparam int M = 1048576;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  square_oscillator_if #(.WIDTH(32)) bus ();

  square_oscillator #(
    .WIDTH(32),
    .FRAC_BITS(20),
    .FILTER_SHIFT(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    bit          chk_c;
    logic [31:0] c;
    bit          chk_o;
    logic [31:0] o;
    bit          chk_f;
    logic [31:0] f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0d (0x%08h) required=%0d (0x%08h)",
               name, $signed(act), act, $signed(req), req);
    end
  endtask

  task automatic drive(input bit s, input logic [31:0] smp, input logic [31:0] cnt,
                       input logic [31:0] wl);
    bus.set         = s;
    bus.set_sample  = smp;
    bus.set_counter = cnt;
    bus.wave_length = wl;
  endtask

  task automatic push_exp(input string name, input bit cc, input logic [31:0] c,
                          input bit co, input logic [31:0] o,
                          input bit cf, input logic [31:0] f);
    exp_t e;
    e.cyc   = cyc + 1;
    e.name  = name;
    e.chk_c = cc;
    e.c     = c;
    e.chk_o = co;
    e.o     = o;
    e.chk_f = cf;
    e.f     = f;
    exp_q.push_back(e);
  endtask

  // Monitor: one line per checked transaction.
  always @(posedge clk) begin
    #1;
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      $display("cyc %0d %s: counter=0x%08h out=0x%08h filtered_out=0x%08h",
               cyc, mon_e.name, bus.counter, bus.out, bus.filtered_out);
      if (mon_e.cyc != cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_stale: actual cycle=%0d required cycle=%0d", mon_e.name, cyc, mon_e.cyc);
      end
      if (mon_e.chk_c) cmp({mon_e.name, "_counter"}, bus.counter, mon_e.c);
      if (mon_e.chk_o) cmp({mon_e.name, "_out"}, bus.out, mon_e.o);
      if (mon_e.chk_f) cmp({mon_e.name, "_filtered"}, bus.filtered_out, mon_e.f);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int fr_c [8] = '{M, 2*M, 3*M, 0, M, 2*M, 3*M, 0};
  int fr_o [8] = '{-M, -M, -M, M, M, M, M, -M};
  int mx_c [16] = '{M, 2*M, 3*M, 0,   3*M, 0, M, 2*M,
                    M, 2*M, 3*M, 0,   3*M, 0, M, 2*M};
  int mx_o [16] = '{-M, -M, -M, M,    M, -M, -M, -M,
                    M, M, M, -M,      -M, M, M, M};
  logic [31:0] ctx_o [2];
  logic [31:0] ctx_c [2];

  initial begin
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    #1 reset = 1'b1;
    #1;
    cmp("reset_counter", bus.counter, 32'd0);
    cmp("reset_out", bus.out, -M);
    cmp("reset_filtered", bus.filtered_out, 32'd0);

    // Free-run from reset: half = 4*STEP, period 8 cycles.
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd8388608);
    for (int i = 0; i < 8; i++) begin
      push_exp("freerun", 1'b1, fr_c[i], 1'b1, fr_o[i], 1'b0, 32'd0);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    cmp("async_reset_counter", bus.counter, 32'd0);
    cmp("async_reset_out", bus.out, -M);
    cmp("async_reset_filtered", bus.filtered_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Load then free-run toggle, with filter tracking a negative output.
    drive(1'b1, -M, 32'd1, 32'd4194304);
    push_exp("load", 1'b1, 32'd1048577, 1'b1, -M, 1'b1, -524288);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 32'd4194304);
    push_exp("toggle", 1'b1, 32'd1, 1'b1, M, 1'b1, -786432);
    @(negedge clk);

    // wave_length = 0 holds the sample.
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    push_exp("hold0", 1'b1, 32'd0, 1'b1, M, 1'b1, 32'd131072);
    @(negedge clk);
    push_exp("hold1", 1'b1, 32'd0, 1'b1, M, 1'b1, 32'd589824);
    @(negedge clk);
    drive(1'b1, 32'd12345, 32'd777, 32'd0);
    push_exp("hold_load", 1'b1, 32'd0, 1'b1, 32'd12345, 1'b0, 32'd0);
    @(negedge clk);

    // half == STEP toggles every cycle.
    drive(1'b0, 32'd0, 32'd0, 32'd2097152);
    for (int i = 0; i < 3; i++) begin
      push_exp("fast_toggle", 1'b1, 32'd0, 1'b1, (i % 2 == 0) ? -12345 : 12345, 1'b0, 32'd0);
      @(negedge clk);
    end

    // half just above STEP takes the counting path.
    drive(1'b1, 32'd777, 32'd0, 32'd2097154);
    push_exp("half_above_step0", 1'b1, 32'd1048576, 1'b1, 32'd777, 1'b0, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 32'd2097154);
    push_exp("half_above_step1", 1'b1, 32'd1048575, 1'b1, -777, 1'b0, 32'd0);
    @(negedge clk);

    // Negation saturation and wide counter sum.
    drive(1'b1, 32'h8000_0000, 32'd0, 32'd2097152);
    push_exp("sat_toggle", 1'b1, 32'd0, 1'b1, 32'h7FFF_FFFF, 1'b0, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'h8000_0000, 32'd0, 32'd0);
    push_exp("sat_hold", 1'b1, 32'd0, 1'b1, 32'h8000_0000, 1'b0, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'h8000_0000, M, 32'd4194304);
    push_exp("sat_wrap_eq", 1'b1, 32'd0, 1'b1, 32'h7FFF_FFFF, 1'b0, 32'd0);
    @(negedge clk);
    drive(1'b1, M, 32'hFFF0_0000, 32'hFFFF_FFFF);
    push_exp("wide_sum", 1'b1, 32'h8000_0001, 1'b1, -M, 1'b0, 32'd0);
    @(negedge clk);

    // Settle the filter to exactly zero by approaching from above.
    drive(1'b1, M, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    repeat (40) @(negedge clk);
    drive(1'b1, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    repeat (39) @(negedge clk);
    push_exp("filt_settle", 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, 32'd0);
    @(negedge clk);

    // Filter step response.
    drive(1'b1, M, 32'd0, 32'hFFFF_FFFF);
    push_exp("filt_step1", 1'b1, M, 1'b1, M, 1'b1, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF);
    push_exp("filt_step2", 1'b1, 2*M, 1'b1, M, 1'b1, 32'd524288);
    @(negedge clk);
    push_exp("filt_step3", 1'b1, 3*M, 1'b1, M, 1'b1, 32'd786432);
    @(negedge clk);
    push_exp("filt_step4", 1'b1, 4*M, 1'b1, M, 1'b1, 32'd917504);
    @(negedge clk);
    push_exp("filt_step5", 1'b1, 5*M, 1'b1, M, 1'b1, 32'd983040);
    @(negedge clk);
    repeat (30) @(negedge clk);
    push_exp("filt_final", 1'b1, 36*M, 1'b1, M, 1'b1, 32'd1048575);
    @(negedge clk);

    // Two contexts multiplexed through one instance, 4 cycles per slot.
    ctx_o[0] = -M; ctx_c[0] = 32'd0;
    ctx_o[1] = M;  ctx_c[1] = 2*M;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0) drive(1'b1, ctx_o[s % 2], ctx_c[s % 2], 32'd8388608);
        else        drive(1'b0, 32'd0, 32'd0, 32'd8388608);
        push_exp((s % 2 == 0) ? "mux_a" : "mux_b", 1'b1, mx_c[s*4+k], 1'b1, mx_o[s*4+k],
                 1'b0, 32'd0);
        @(negedge clk);
      end
      ctx_o[s % 2] = bus.out;
      ctx_c[s % 2] = bus.counter;
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
